// File: rtl/dmem_pkg.sv
// Shared widths, word type and parity helper for the data memory.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 16;
   localparam int DMEM_DATA_W = 8;
   localparam int PAR_VEC_W   = 64;

   typedef logic [DMEM_DATA_W-1:0] word_t;

   // Callers zero-extend narrower data, which leaves the reduction unchanged.
   function automatic logic parity(input logic [PAR_VEC_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Raw storage: synchronous write and a registered, read-first read port.
// Contents power up as zero; there is no reset on the array.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = DMEM_ADDR_W,
   parameter int WORD_WIDTH = DMEM_DATA_W
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [WORD_WIDTH-1:0] mem [DEPTH] = '{default: {WORD_WIDTH{1'b0}}};

   // Read samples the pre-write contents, so a same-address collision returns old data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end else begin
         rdata <= rdata;
      end
   end

endmodule

// File: rtl/data_memory.sv
// Byte-wide single-port data RAM with 1-cycle registered read and held output.
// Optional per-word even parity is enabled with the DMEM_PARITY_EN macro.
module data_memory
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = DMEM_ADDR_W,
   parameter int DATA_WIDTH = DMEM_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
`ifdef DMEM_PARITY_EN
   output logic                  parity_err,
`endif
   output logic [DATA_WIDTH-1:0] data_out
);

`ifdef DMEM_PARITY_EN
   localparam int WORD_W = DATA_WIDTH + 1;
`else
   localparam int WORD_W = DATA_WIDTH;
`endif

   logic              we_s;
   logic              re_s;
   logic [WORD_W-1:0] wdata_s;
   logic [WORD_W-1:0] rdata_s;
   logic              cleared_r;

   assign we_s = write_en & ~rst;
   assign re_s = read_en & ~rst;

`ifdef DMEM_PARITY_EN
   assign wdata_s = {parity(PAR_VEC_W'(data_in)), data_in};
`else
   assign wdata_s = data_in;
`endif

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_W)
   ) u_array (
      .clk   (clk),
      .we    (we_s),
      .re    (re_s),
      .addr  (addr),
      .wdata (wdata_s),
      .rdata (rdata_s)
   );

   // Masks the array read register to zero from reset until the next read refreshes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cleared_r <= 1'b1;
      end else if (read_en) begin
         cleared_r <= 1'b0;
      end else begin
         cleared_r <= cleared_r;
      end
   end

   // Output view of the held read register.
   always_comb begin
      data_out = {DATA_WIDTH{1'b0}};
      if (cleared_r) begin
         data_out = {DATA_WIDTH{1'b0}};
      end else begin
         data_out = rdata_s[DATA_WIDTH-1:0];
      end
   end

`ifdef DMEM_PARITY_EN
   // Parity check on the held read word; follows data_out timing exactly.
   always_comb begin
      parity_err = 1'b0;
      if (cleared_r) begin
         parity_err = 1'b0;
      end else begin
         parity_err = rdata_s[DATA_WIDTH] != parity(PAR_VEC_W'(rdata_s[DATA_WIDTH-1:0]));
      end
   end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed scoreboard bench for data_memory; parity checks when DMEM_PARITY_EN is defined.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_en;
   logic        read_en;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
`ifdef DMEM_PARITY_EN
   logic        parity_err;
`endif

   typedef struct {
      logic [7:0] data;
      logic       perr;
      string      tag;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  ref_mem [logic [15:0]];
   bit          flipped [logic [15:0]];
   logic [7:0]  m_dout;
   logic        m_perr;
   int          checks = 0;
   int          passed = 0;

   data_memory #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .write_en   (write_en),
      .read_en    (read_en),
      .addr       (addr),
      .data_in    (data_in),
`ifdef DMEM_PARITY_EN
      .parity_err (parity_err),
`endif
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst === 1'b0) begin
         assert (!$isunknown({write_en, read_en}))
         else $error("strobe X while out of reset");
      end
   end

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 8'h00;
   endfunction

   task automatic step(input logic r, input logic we, input logic re,
                       input logic [15:0] a, input logic [7:0] d, input string tag);
      exp_t e;
      rst = r; write_en = we; read_en = re; addr = a; data_in = d;
      if (r) begin
         m_dout = 8'h00;
         m_perr = 1'b0;
      end else if (re) begin
         m_dout = ref_rd(a);
         m_perr = flipped.exists(a);
      end
      if (!r && we) begin
         ref_mem[a] = d;
         if (flipped.exists(a)) flipped.delete(a);
      end
      e.data = m_dout;
      e.perr = m_perr;
      e.tag  = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (data_out === e.data) passed++;
      else $error("FAIL %s data_out got %h want %h", e.tag, data_out, e.data);
`ifdef DMEM_PARITY_EN
      checks++;
      assert (parity_err === e.perr) passed++;
      else $error("FAIL %s parity_err got %b want %b", e.tag, parity_err, e.perr);
`endif
   endtask

   initial begin
      rst = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = 16'h0000; data_in = 8'h00;
      m_dout = 8'h00; m_perr = 1'b0;

      step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, "reset0");
      step(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, "reset1");
      step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, "pwrup_ff00");
      step(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, "pwrup_0000");

      step(1'b0, 1'b1, 1'b0, 16'hFF00, 8'hE4, "wr_ff00_hold");
      step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, "rd_ff00");
      step(1'b0, 1'b1, 1'b0, 16'h0001, 8'h5A, "hold_during_wr");
      step(1'b0, 1'b0, 1'b0, 16'h0001, 8'h00, "hold_idle");

      step(1'b0, 1'b1, 1'b0, 16'h0010, 8'h11, "wr_0010");
      step(1'b0, 1'b1, 1'b1, 16'h0010, 8'h22, "collide_old");
      step(1'b0, 1'b0, 1'b1, 16'h0010, 8'h00, "collide_new");

      step(1'b1, 1'b1, 1'b0, 16'h0020, 8'h77, "rst_mid_wr");
      step(1'b0, 1'b0, 1'b1, 16'h0020, 8'h00, "rd_0020_suppressed");
      step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, "rd_ff00_kept");
      step(1'b0, 1'b0, 1'b1, 16'h0001, 8'h00, "rd_0001");

      step(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'hA5, "wr_ffff");
      step(1'b0, 1'b1, 1'b0, 16'h0000, 8'h3C, "wr_0000");
      step(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h00, "rd_ffff");
      step(1'b0, 1'b0, 1'b1, 16'h7FFF, 8'h00, "rd_7fff_no_alias");
      step(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, "rd_0000");

      step(1'b0, 1'b1, 1'b1, 16'hFF00, 8'h99, "rw_same_ff00");
      step(1'b0, 1'b1, 1'b0, 16'h0002, 8'h99, "wr_0002");
      step(1'b0, 1'b0, 1'b1, 16'h0002, 8'h00, "rd_0002");
      step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, "rd_ff00_new");

      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              16'($urandom_range(16'h0043, 16'h0040)), 8'($urandom_range(255, 0)), "rand");
      end

`ifdef DMEM_PARITY_EN
      step(1'b0, 1'b1, 1'b0, 16'h0030, 8'h07, "par_wr");
      u_dut.u_array.mem[16'h0030][8] = ~u_dut.u_array.mem[16'h0030][8];
      flipped[16'h0030] = 1'b1;
      step(1'b0, 1'b0, 1'b1, 16'h0030, 8'h00, "par_err");
      step(1'b0, 1'b0, 1'b0, 16'h0030, 8'h00, "par_hold");
      step(1'b0, 1'b0, 1'b1, 16'hFF00, 8'h00, "par_clean");
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port, byte-wide, synchronous data RAM for the CPU datapath, sitting behind the load/store unit.
- Writes land on the rising clock edge.
- Reads are registered and appear one cycle after the request.
- `data_out` holds its value between reads, so the load path can sample it late.

Parameters:
- ADDR_WIDTH, 16, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- write_en  input  1  write strobe, sampled at posedge
- read_en  input  1  read strobe, sampled at posedge
- addr  input  ADDR_WIDTH  word address, shared by read and write
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data
- parity_err  output  1  parity mismatch on last read; present only with DMEM_PARITY_EN

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - At a posedge with rst=1: data_out <= 0, parity_err <= 0.
  - Any write requested that cycle is suppressed.
  - Array contents are NOT cleared by reset.
- Power-up: array contents are zero at time 0 (initial fill). A read before any write returns 0x00.
- Write: posedge, rst=0, write_en=1 -> mem[addr] <= data_in. Full-width write only; no byte enables.
- Read: posedge, rst=0, read_en=1 -> data_out <= mem[addr]. Latency is exactly 1 cycle from the sampling edge.
- Hold: read_en=0 -> data_out keeps its previous value. Writes never disturb data_out.
- Read and write in the same cycle, same address: read-first. data_out gets the OLD contents; the new value is visible to reads from the next cycle.
- Read and write in the same cycle, different addresses: both operations are performed independently.
- Address space: full range 0 .. 2**ADDR_WIDTH-1 is valid. No wrap or aliasing; all addr bits decode.
- X handling: X on write_en or read_en during rst=0 is a protocol violation. The verification bench asserts against it.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- With DMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed from data_in at write time.
  - On a read, parity_err <= (stored parity != ^stored data), with the same 1-cycle latency as data_out.
  - parity_err holds when read_en=0 and is cleared by rst.
  - Power-up fill includes parity 0, which is consistent for the all-zero data.
- Without the macro: no parity storage and no parity_err port; array width is DATA_WIDTH.

Decomposition:
- Package dmem_pkg holds:
  - default widths: DMEM_ADDR_W=16, DMEM_DATA_W=8;
  - word typedef;
  - a parity function returning the XOR-reduce.
- One sub-module is natural: dmem_array, the raw storage.
  - Synchronous write, registered read-first read port.
  - Width = DATA_WIDTH (+1 with parity).
- data_memory wraps dmem_array and adds the reset/hold logic on data_out and the parity check.

Test Plan:
- After reset: read_en=1, addr=0xFF00 -> data_out=0x00 one cycle later. Change addr to 0x0000 -> data_out=0x00.
- Write then read: write_en=1, addr=0xFF00, data_in=0xE4. Next cycle read_en=1, write_en=0 -> data_out=0xE4 one cycle after the read edge.
- Hold: after reading 0xE4, drop read_en and write 0x5A to 0x0001 -> data_out stays 0xE4.
- Read-first collision: mem[0x0010]=0x11. Read and write 0x22 to 0x0010 in one cycle -> data_out=0x11. Following read -> 0x22.
- Reset mid-operation: rst=1 with write_en=1, addr=0x0020, data_in=0x77 -> data_out=0x00, and a later read of 0x0020 returns the prior value (0x00). A previously written 0xFF00 still reads 0xE4.
- Parity (DMEM_PARITY_EN): write 0x07 to 0x0030, force-flip the stored parity bit via hierarchical access, read -> parity_err=1. A clean read of 0xFF00 -> parity_err=0.
